// File: rtl/centroid_accumulator_param.sv
// Weighted centroid-moment accumulator: SUM(w), SUM(w*x), SUM(w*y) over one raster frame,
// result held under VALID/RES_READY. Optional bounding box when CENTROID_BBOX_EN is defined.
module centroid_accumulator_param #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 1,
    localparam int X_W   = $clog2(IMG_W),
    localparam int Y_W   = $clog2(IMG_H),
    localparam int SUM_W = PIX_W + X_W + Y_W,
    localparam int H_W   = SUM_W + X_W,
    localparam int V_W   = SUM_W + Y_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SOF,
    input  logic             DIN_VALID,
    input  logic [PIX_W-1:0] DIN,
    output logic             DIN_READY,
    input  logic [PIX_W-1:0] THRESH,
    output logic [H_W-1:0]   H_TOTAL,
    output logic [V_W-1:0]   V_TOTAL,
    output logic [SUM_W-1:0] SUM,
    output logic             VALID,
    input  logic             RES_READY,
    output logic             FRAME_ERR
`ifdef CENTROID_BBOX_EN
    ,
    output logic [X_W-1:0]   X_MIN,
    output logic [X_W-1:0]   X_MAX,
    output logic [Y_W-1:0]   Y_MIN,
    output logic [Y_W-1:0]   Y_MAX
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [X_W-1:0]   h_cnt;
    logic [Y_W-1:0]   v_cnt;
    logic             accept;
    logic [PIX_W-1:0] w;
    logic [H_W-1:0]   h_term;
    logic [V_W-1:0]   v_term;
    logic             h_last;
    logic             last_pix;

    assign DIN_READY = (state != HOLD);

    always_comb begin
        accept   = DIN_VALID & DIN_READY;
        w        = (DIN >= THRESH) ? DIN : '0;
        h_term   = H_W'(w) * H_W'(h_cnt);
        v_term   = V_W'(w) * V_W'(v_cnt);
        h_last   = (h_cnt == X_W'(IMG_W - 1));
        last_pix = h_last && (v_cnt == Y_W'(IMG_H - 1));
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            H_TOTAL   <= '0;
            V_TOTAL   <= '0;
            SUM       <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef CENTROID_BBOX_EN
            X_MIN     <= X_W'(IMG_W - 1);
            X_MAX     <= '0;
            Y_MIN     <= Y_W'(IMG_H - 1);
            Y_MAX     <= '0;
`endif
        end else begin
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (accept && SOF) begin
                        // SOF pixel is (0,0): its moment terms are zero, old frame discarded
                        SUM       <= SUM_W'(w);
                        H_TOTAL   <= '0;
                        V_TOTAL   <= '0;
                        h_cnt     <= X_W'(1);
                        v_cnt     <= '0;
                        state     <= ACCUM;
                        FRAME_ERR <= (state == ACCUM);
`ifdef CENTROID_BBOX_EN
                        X_MIN     <= (w != '0) ? '0 : X_W'(IMG_W - 1);
                        Y_MIN     <= (w != '0) ? '0 : Y_W'(IMG_H - 1);
                        X_MAX     <= '0;
                        Y_MAX     <= '0;
`endif
                    end else if (accept && state == ACCUM) begin
                        SUM     <= SUM + SUM_W'(w);
                        H_TOTAL <= H_TOTAL + h_term;
                        V_TOTAL <= V_TOTAL + v_term;
`ifdef CENTROID_BBOX_EN
                        if (w != '0) begin
                            if (h_cnt < X_MIN) X_MIN <= h_cnt;
                            if (h_cnt > X_MAX) X_MAX <= h_cnt;
                            if (v_cnt < Y_MIN) Y_MIN <= v_cnt;
                            if (v_cnt > Y_MAX) Y_MAX <= v_cnt;
                        end
`endif
                        if (last_pix) begin
                            h_cnt <= '0;
                            v_cnt <= '0;
                            state <= HOLD;
                            VALID <= 1'b1;
                        end else if (h_last) begin
                            h_cnt <= '0;
                            v_cnt <= v_cnt + Y_W'(1);
                        end else begin
                            h_cnt <= h_cnt + X_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (RES_READY) begin
                        state <= IDLE;
                        VALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
